fifo_drain: RTL

- Read-side controller for the 6-bit FIFO. It issues fifo_rd only when the FIFO is non-empty and local space exists, and absorbs the FIFO's one-cycle read latency.
- Delivers words in order to a downstream consumer over a valid/ready handshake, with a 2-entry skid buffer so no read word is ever lost.
- Sits between the FIFO's data_out/fifo_empty and the next pipeline stage. Provides enable/flush control and a delivered-word count.

---
 rtl/fifo_drain.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - FIFO read-side drain controller with 2-entry skid buffer
module fifo_drain #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_read
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            occ;
    logic                  pend;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic                  space;

    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
    assign pop       = out_valid & out_ready;
    assign busy      = (state != IDLE);

    // Room must cover the word already in flight; a same-cycle pop frees one slot.
    assign space = ({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                fifo_rd = enable & ~fifo_empty & space & ~RESET;
                if (!enable) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (enable)
                    state_nxt = RUN;
                else if (occ == 2'd0 && !pend)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            occ        <= 2'd0;
            pend       <= 1'b0;
            head       <= '0;
            tail       <= '0;
            words_read <= '0;
        end else begin
            state <= state_nxt;
            pend  <= fifo_rd;
            if (pop) words_read <= words_read + CNT_ONE;
            // Capture of an in-flight word is unconditional: space was reserved at issue.
            case ({pop, pend})
                2'b01: begin
                    if (occ == 2'd0) head <= fifo_data;
                    else             tail <= fifo_data;
                    occ <= occ + 2'd1;
                end
                2'b10: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= fifo_data;
                    end else begin
                        head <= tail;
                        tail <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
